tm1638_modn_counter: RTL

- Parametrised successor to the mod-60 LED 7-segment counter.
- Up/down modulo-N counter with enable and clear, DIGITS-wide BCD display.
- Drives a TM1638-style 3-wire display (stb/sclk/dio) and refreshes the whole display frame whenever the count changes.
- Sits at the top of the board design on Clk_50M.

---
 rtl/tm1638_modn_counter_if.sv | 16 +
 rtl/tm1638_modn_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_modn_counter_if.sv
// ---------------------------------------------------------------------------
// tm1638_modn_counter_if
// Three-wire TM1638-style display bus.
//   dio  : serial data, LSB first, sampled by the receiver on sclk rising edge
//   sclk : serial clock, idles high
//   stb  : active-low strobe framing each command/data group
// master drives the bus (the counter), slave observes it (display or bench).
// ---------------------------------------------------------------------------
interface tm1638_modn_counter_if;
  logic dio;
  logic sclk;
  logic stb;

  modport master (output dio, sclk, stb);
  modport slave  (input  dio, sclk, stb);
endinterface

// File: rtl/tm1638_modn_counter.sv
// ---------------------------------------------------------------------------
// tm1638_modn_counter
// Up/down modulo-MODULUS counter with a tick prescaler, shown as DIGITS BCD
// digits on a TM1638-style display. A full 19-byte display frame is sent
// every time the count changes.
// Ports:
//   Clk_50M    : system clock
//   RST        : asynchronous active-low reset
//   en         : count enable (sampled on prescaler tick)
//   up_dn      : 1 = count up, 0 = count down
//   clr        : synchronous clear of count and prescaler (beats tick)
//   count      : current binary count
//   busy       : high while a frame is on the bus (low only in IDLE)
//   data_check : last fully transmitted byte
//   disp       : display bus (dio/sclk/stb)
// ---------------------------------------------------------------------------
module tm1638_modn_counter #(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1,
  parameter int MODULUS  = 60,
  parameter int DIGITS   = 2,
  parameter int SCLK_DIV = 25,
  parameter int BRIGHT   = 7,
  localparam int CW      = $clog2(MODULUS)
) (
  input  logic                  Clk_50M,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  output logic [CW-1:0]         count,
  output logic                  busy,
  output logic [7:0]            data_check,
  tm1638_modn_counter_if.master disp
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = $clog2(2 * SCLK_DIV);

  typedef enum logic [2:0] {IDLE, STB_LO, BIT_LO, BIT_HI, BYTE_END, STB_HI} state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [CW-1:0]    count_nxt;
  logic             count_chg;
  logic             pending;
  logic [DW-1:0]    div_cnt;
  logic             half_done;
  logic             stb_hold_done;
  logic [2:0]       bit_idx;
  logic [4:0]       byte_idx;
  logic             group_last;
  logic [7:0][7:0]  seg_all;   // segment code per digit, digit 0 leftmost
  logic [7:0][7:0]  snap;      // digits frozen for the frame on the bus
  logic [7:0]       cur_byte;
  logic [7:0]       nxt_byte;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      default: seg7 = 8'h6F;
    endcase
  endfunction

  // Byte idx of the 19-byte frame: 0x40 | 0xC0 + 16 data | 0x88|BRIGHT.
  // Data address a = idx-2; even addresses carry digit a/2, odd are blank.
  function automatic logic [7:0] frame_byte(input logic [4:0] idx,
                                            input logic [7:0][7:0] digits);
    logic [4:0] addr;
    addr       = idx - 5'd2;
    frame_byte = 8'h00;
    if (idx == 5'd0)       frame_byte = 8'h40;
    else if (idx == 5'd1)  frame_byte = 8'hC0;
    else if (idx == 5'd18) frame_byte = 8'h88 | 8'(BRIGHT & 7);
    else if (!idx[0])      frame_byte = digits[addr[3:1]];
  endfunction

  assign tick = (presc == PW'(DIV - 1));

  // NOTE: every signal written in always_comb gets a default on entry, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (tick && en) begin
      if (up_dn) count_nxt = (count == CW'(MODULUS - 1)) ? '0 : count + CW'(1);
      else       count_nxt = (count == '0) ? CW'(MODULUS - 1) : count - CW'(1);
    end
  end

  assign count_chg = (count_nxt != count);

  // Binary to BCD by repeated divide-by-10, least significant digit last
  // position; positions beyond DIGITS stay blank.
  always_comb begin
    logic [31:0] rem;
    seg_all = '0;
    rem     = 32'(count);
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seg_all[i] = seg7(4'(rem % 32'd10));
      rem        = rem / 32'd10;
    end
  end

  assign cur_byte      = frame_byte(byte_idx, snap);
  assign nxt_byte      = frame_byte(byte_idx + 5'd1, snap);
  assign half_done     = (div_cnt == DW'(SCLK_DIV - 1));
  assign stb_hold_done = (div_cnt == DW'(2 * SCLK_DIV - 1));
  assign group_last    = (byte_idx == 5'd0) || (byte_idx >= 5'd17);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk_50M or negedge RST) begin
    if (!RST) begin
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset
      // with everything else.
      state      <= IDLE;
      presc      <= '0;
      count      <= '0;
      pending    <= 1'b1;
      div_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      snap       <= '0;
      busy       <= 1'b0;
      data_check <= 8'h00;
      disp.dio   <= 1'b1;
      disp.sclk  <= 1'b1;
      disp.stb   <= 1'b1;
    end else begin
      presc <= (clr || tick) ? '0 : presc + PW'(1);
      count <= count_nxt;

      // A change on the same cycle a frame launches must keep pending set,
      // since the snapshot captured the old count.
      if (count_chg)                    pending <= 1'b1;
      else if (state == IDLE && pending) pending <= 1'b0;

      case (state)
        IDLE: begin
          disp.dio  <= 1'b1;
          disp.sclk <= 1'b1;
          disp.stb  <= 1'b1;
          busy      <= 1'b0;
          if (pending) begin
            snap     <= seg_all;
            byte_idx <= '0;
            bit_idx  <= '0;
            div_cnt  <= '0;
            disp.stb <= 1'b0;
            busy     <= 1'b1;
            state    <= STB_LO;
          end
        end

        STB_LO: begin
          if (half_done) begin
            div_cnt   <= '0;
            disp.sclk <= 1'b0;
            disp.dio  <= cur_byte[0];
            state     <= BIT_LO;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        BIT_LO: begin
          if (half_done) begin
            div_cnt   <= '0;
            disp.sclk <= 1'b1;
            state     <= BIT_HI;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        BIT_HI: begin
          if (half_done) begin
            div_cnt <= '0;
            if (bit_idx == 3'd7) begin
              data_check <= cur_byte;
              bit_idx    <= '0;
              if (group_last) begin
                state <= BYTE_END;
              end else begin
                // Bytes within a group run back-to-back.
                byte_idx  <= byte_idx + 5'd1;
                disp.sclk <= 1'b0;
                disp.dio  <= nxt_byte[0];
                state     <= BIT_LO;
              end
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              disp.sclk <= 1'b0;
              disp.dio  <= cur_byte[bit_idx + 3'd1];
              state     <= BIT_LO;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        BYTE_END: begin
          if (half_done) begin
            div_cnt  <= '0;
            disp.stb <= 1'b1;
            disp.dio <= 1'b1;
            state    <= STB_HI;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        STB_HI: begin
          if (stb_hold_done) begin
            div_cnt <= '0;
            if (byte_idx == 5'd18) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 5'd1;
              disp.stb <= 1'b0;
              state    <= STB_LO;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
